// File: rtl/trading_npu_top.sv
// Low-latency trading core: GMII frame parser, AXI4-Lite weight/threshold registers,
// 8-PE dot-product scorer and active-low decision LEDs, all on a single clock.
module trading_npu_top #(
    parameter int unsigned LED_PULSE_TICKS = 50_000_000,
    parameter logic [31:0] SYMBOL          = 32'h30303530
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic [5:0]  s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [5:0]  s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        led_buy,
    output logic        led_sell,
    output logic        led_activity,
    output logic        led_idle
);

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_PREAMBLE = 2'd1;
    localparam logic [1:0]  ST_DATA     = 2'd2;
    localparam logic [1:0]  ST_DROP     = 2'd3;
    localparam logic [31:0] PULSE       = 32'(LED_PULSE_TICKS);

    // cfg_reg[0..7] are the weights, cfg_reg[8] is the threshold
    logic [31:0] cfg_reg [0:8];
    logic        awready_reg, wready_reg, bvalid_reg;
    logic        arready_reg, rvalid_reg;
    logic [31:0] rdata_reg;
    logic [3:0]  wr_idx, rd_idx;
    logic        unused_ok;

    assign wr_idx        = s_axi_awaddr[5:2];
    assign rd_idx        = s_axi_araddr[5:2];
    assign unused_ok     = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
    assign s_axi_awready = awready_reg;
    assign s_axi_wready  = wready_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = 2'b00;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            for (int i = 0; i < 9; i++) cfg_reg[i] <= '0;
        end else begin
            awready_reg <= !awready_reg && s_axi_awvalid && s_axi_wvalid && !bvalid_reg;
            wready_reg  <= !awready_reg && s_axi_awvalid && s_axi_wvalid && !bvalid_reg;
            if (awready_reg) begin
                bvalid_reg <= 1'b1;
                if (wr_idx < 4'd9) begin
                    for (int b = 0; b < 4; b++)
                        if (s_axi_wstrb[b]) cfg_reg[wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end else if (bvalid_reg && s_axi_bready) begin
                bvalid_reg <= 1'b0;
            end

            arready_reg <= !arready_reg && s_axi_arvalid && !rvalid_reg;
            if (arready_reg) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= (rd_idx < 4'd9) ? cfg_reg[rd_idx] : '0;
            end else if (rvalid_reg && s_axi_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    logic [1:0]  state_reg;
    logic [5:0]  byte_cnt_reg;
    logic [31:0] symbol_reg, price_reg;
    logic        price_valid_reg;
    logic        sfd_det;

    assign sfd_det = (state_reg == ST_PREAMBLE) && gmii_rx_dv && (gmii_rxd == 8'hD5);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg       <= ST_IDLE;
            byte_cnt_reg    <= '0;
            symbol_reg      <= '0;
            price_reg       <= '0;
            price_valid_reg <= 1'b0;
        end else begin
            price_valid_reg <= 1'b0;
            if (!gmii_rx_dv) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: state_reg <= (gmii_rxd == 8'h55) ? ST_PREAMBLE : ST_DROP;
                    ST_PREAMBLE: begin
                        if (gmii_rxd == 8'hD5) begin
                            state_reg    <= ST_DATA;
                            byte_cnt_reg <= '0;
                        end else if (gmii_rxd != 8'h55) begin
                            state_reg <= ST_DROP;
                        end
                    end
                    ST_DATA: begin
                        if (byte_cnt_reg >= 6'd42 && byte_cnt_reg <= 6'd45)
                            symbol_reg <= {symbol_reg[23:0], gmii_rxd};
                        if (byte_cnt_reg >= 6'd46 && byte_cnt_reg <= 6'd49)
                            price_reg <= {price_reg[23:0], gmii_rxd};
                        // symbol is complete by byte 45, so it can be tested as byte 49 lands
                        if (byte_cnt_reg == 6'd49 && symbol_reg == SYMBOL)
                            price_valid_reg <= 1'b1;
                        if (byte_cnt_reg != 6'd63)
                            byte_cnt_reg <= byte_cnt_reg + 6'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic        s1_valid_reg, s2_valid_reg, s3_valid_reg, s4_valid_reg;
    logic [31:0] s1_price_reg;
    logic [31:0] s1_weight_reg [0:7];
    logic [63:0] prod_next [0:7];
    logic [63:0] prod_reg [0:7];
    logic [65:0] half_next [0:1];
    logic [65:0] half_reg [0:1];
    logic [66:0] sum_reg, thr_ext;
    logic        sell_hit, buy_hit;

    // Low 64 bits of the unsigned product equal the signed product of weight and {0,price}
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pe
            assign prod_next[gi] = {{32{s1_weight_reg[gi][31]}}, s1_weight_reg[gi]} * {32'd0, s1_price_reg};
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half_next[gi] = {{2{prod_reg[4*gi][63]}},   prod_reg[4*gi]}
                                 + {{2{prod_reg[4*gi+1][63]}}, prod_reg[4*gi+1]}
                                 + {{2{prod_reg[4*gi+2][63]}}, prod_reg[4*gi+2]}
                                 + {{2{prod_reg[4*gi+3][63]}}, prod_reg[4*gi+3]};
        end
    endgenerate

    assign thr_ext  = {{35{cfg_reg[8][31]}}, cfg_reg[8]};
    assign sell_hit = s4_valid_reg && ($signed(sum_reg) > $signed(thr_ext));
    assign buy_hit  = s4_valid_reg && ($signed(sum_reg) < $signed(thr_ext));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
            s4_valid_reg <= 1'b0;
            s1_price_reg <= '0;
            sum_reg      <= '0;
            for (int i = 0; i < 8; i++) begin
                s1_weight_reg[i] <= '0;
                prod_reg[i]      <= '0;
            end
            for (int i = 0; i < 2; i++) half_reg[i] <= '0;
        end else begin
            s1_valid_reg <= price_valid_reg;
            s1_price_reg <= price_reg;
            for (int i = 0; i < 8; i++) begin
                s1_weight_reg[i] <= cfg_reg[i];
                prod_reg[i]      <= prod_next[i];
            end
            s2_valid_reg <= s1_valid_reg;
            s3_valid_reg <= s2_valid_reg;
            for (int i = 0; i < 2; i++) half_reg[i] <= half_next[i];
            s4_valid_reg <= s3_valid_reg;
            sum_reg      <= {half_reg[0][65], half_reg[0]} + {half_reg[1][65], half_reg[1]};
        end
    end

    logic [31:0] buy_cnt_reg, sell_cnt_reg, act_cnt_reg;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            buy_cnt_reg  <= '0;
            sell_cnt_reg <= '0;
            act_cnt_reg  <= '0;
        end else begin
            if (sell_hit) begin
                sell_cnt_reg <= PULSE;
                buy_cnt_reg  <= '0;
            end else if (buy_hit) begin
                buy_cnt_reg  <= PULSE;
                sell_cnt_reg <= '0;
            end else begin
                if (sell_cnt_reg != '0) sell_cnt_reg <= sell_cnt_reg - 32'd1;
                if (buy_cnt_reg != '0)  buy_cnt_reg  <= buy_cnt_reg - 32'd1;
            end
            if (sfd_det)                act_cnt_reg <= PULSE;
            else if (act_cnt_reg != '0) act_cnt_reg <= act_cnt_reg - 32'd1;
        end
    end

    assign led_buy      = (buy_cnt_reg == '0);
    assign led_sell     = (sell_cnt_reg == '0);
    assign led_activity = (act_cnt_reg == '0);
    assign led_idle     = !sys_rst_n || !led_buy || !led_sell || !led_activity;

endmodule

// File: tb/tb_trading_npu_top.sv
// Scoreboard bench for trading_npu_top: frames push expected decisions, an LED monitor
// pops them as BUY/SELL pulses appear.
module tb_trading_npu_top;

    localparam int          TICKS = 100;
    localparam logic [31:0] SYM   = 32'h30303530;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic [5:0]  s_axi_awaddr, s_axi_araddr;
    logic [2:0]  s_axi_awprot, s_axi_arprot;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;
    logic        led_buy, led_sell, led_activity, led_idle;

    trading_npu_top #(.LED_PULSE_TICKS(TICKS), .SYMBOL(SYM)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .led_buy(led_buy), .led_sell(led_sell),
        .led_activity(led_activity), .led_idle(led_idle)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    typedef struct {
        int   kind;
        int   cyc;
        logic other;
    } ev_t;

    ev_t  obs_q[$];
    int   exp_q[$];
    int   drv_q[$];
    ev_t  mon_ev;
    logic pb = 1'b1, ps = 1'b1, pa = 1'b1;
    int   buy_fall, buy_rise, sell_fall, sell_rise, act_falls = 0;

    // LED monitor: samples just after each rising edge
    always @(posedge sys_clk) begin
        #1;
        cyc++;
        if (sys_rst_n) begin
            if (pb && !led_buy) begin
                mon_ev.kind = 1; mon_ev.cyc = cyc; mon_ev.other = led_sell;
                obs_q.push_back(mon_ev);
                buy_fall = cyc;
            end
            if (ps && !led_sell) begin
                mon_ev.kind = 2; mon_ev.cyc = cyc; mon_ev.other = led_buy;
                obs_q.push_back(mon_ev);
                sell_fall = cyc;
            end
            if (!pb && led_buy)  buy_rise = cyc;
            if (!ps && led_sell) sell_rise = cyc;
            if (pa && !led_activity) act_falls++;
        end
        pb = led_buy;
        ps = led_sell;
        pa = led_activity;
    end

    int tb_w[8];
    int tb_thr;

    function automatic int model_kind(input logic [31:0] price);
        logic signed [66:0] sum, w, p, t;
        sum = '0;
        p   = {35'd0, price};
        for (int i = 0; i < 8; i++) begin
            w   = 67'(tb_w[i]);
            sum = sum + w * p;
        end
        t = 67'(tb_thr);
        if (sum > t) return 2;
        if (sum < t) return 1;
        return 0;
    endfunction

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge sys_clk);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge sys_clk);
            if (s_axi_awready && s_axi_wready) break;
        end
        if (n == 20) check_val("aw_timeout", 64'd0, 64'd1);
        @(posedge sys_clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check_val("bresp", {61'd0, s_axi_bvalid, s_axi_bresp}, 64'd4);
        s_axi_bready = 1'b1;
        @(posedge sys_clk); #1;
        s_axi_bready = 1'b0;
        if (strb == 4'hF) begin
            if (addr < 6'h20) tb_w[addr[4:2]] = data;
            else if (addr == 6'h20) tb_thr = data;
        end
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
        int n;
        @(negedge sys_clk);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge sys_clk);
            if (s_axi_arready) break;
        end
        if (n == 20) check_val("ar_timeout", 64'd0, 64'd1);
        @(posedge sys_clk); #1;
        s_axi_arvalid = 1'b0;
        check_val("rresp", {61'd0, s_axi_rvalid, s_axi_rresp}, 64'd4);
        data = s_axi_rdata;
        s_axi_rready = 1'b1;
        @(posedge sys_clk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] sym, input logic [31:0] price, input int len, input int gap);
        int drv = 0;
        exp_q.push_back((len > 49 && sym == SYM) ? model_kind(price) : 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge sys_clk);
            gmii_rx_dv = 1'b1; gmii_rxd = 8'h55;
        end
        @(negedge sys_clk);
        gmii_rxd = 8'hD5;
        for (int i = 0; i < len; i++) begin
            @(negedge sys_clk);
            if (i >= 42 && i <= 45)      gmii_rxd = sym[8*(45-i) +: 8];
            else if (i >= 46 && i <= 49) gmii_rxd = price[8*(49-i) +: 8];
            else                         gmii_rxd = i[7:0];
            if (i == 49) drv = cyc;
        end
        @(negedge sys_clk);
        gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
        repeat (gap - 1) @(negedge sys_clk);
        drv_q.push_back(drv);
    endtask

    task automatic expect_result();
        int  exp_k, dc, n;
        ev_t ev;
        exp_k = exp_q.pop_front();
        dc    = drv_q.pop_front();
        for (n = 0; n < 20 && obs_q.size() == 0; n++) @(negedge sys_clk);
        if (exp_k == 0) begin
            check_val("no_decision", 64'(obs_q.size()), 64'd0);
            obs_q.delete();
        end else if (obs_q.size() == 0) begin
            check_val("decision_timeout", 64'd0, 64'(exp_k));
        end else begin
            ev = obs_q.pop_front();
            check_val("kind", 64'(ev.kind), 64'(exp_k));
            check_val("latency", 64'(ev.cyc - dc), 64'd6);
            check_val("other_led_high", {63'd0, ev.other}, 64'd1);
        end
    endtask

    task automatic wait_quiet(input string tag);
        for (int n = 0; n < 400; n++) begin
            @(negedge sys_clk);
            if (led_buy && led_sell && led_activity) break;
        end
        check_val({tag, "_idle"}, {63'd0, led_idle}, 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, mask, old_thr;
        int act0;
        sys_rst_n = 1'b0; gmii_rxd = '0; gmii_rx_dv = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        for (int i = 0; i < 8; i++) tb_w[i] = 0;
        tb_thr = 0;

        repeat (4) @(negedge sys_clk);
        check_val("rst_leds", {60'd0, led_buy, led_sell, led_activity, led_idle}, 64'hF);
        check_val("rst_axi", {59'd0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 64'd0);
        check_val("rst_rdata", {32'd0, s_axi_rdata}, 64'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_val("post_rst_idle", {63'd0, led_idle}, 64'd0);
        axi_read(6'h04, rd);
        check_val("rst_weight1", {32'd0, rd}, 64'd0);

        for (int i = 0; i < 8; i++) axi_write(6'(i * 4), 32'd1, 4'hF);
        axi_write(6'h20, 32'd100, 4'hF);
        axi_read(6'h0C, rd);
        check_val("rd_weight3", {32'd0, rd}, 64'd1);
        axi_read(6'h20, rd);
        check_val("rd_thr", {32'd0, rd}, 64'd100);

        send_frame(SYM, 32'd20, 60, 2);
        expect_result();
        wait_quiet("sell");
        check_val("sell_width", 64'(sell_rise - sell_fall), 64'(TICKS));

        send_frame(SYM, 32'd10, 60, 2);
        expect_result();
        wait_quiet("buy");
        check_val("buy_width", 64'(buy_rise - buy_fall), 64'(TICKS));

        for (int i = 0; i < 8; i++) axi_write(6'(i * 4), 32'd10, 4'hF);
        axi_write(6'h20, 32'd800, 4'hF);
        act0 = act_falls;
        send_frame(SYM, 32'd10, 60, 2);
        expect_result();
        check_val("act_pulse", 64'(act_falls - act0), 64'd1);
        wait_quiet("equal");

        send_frame(32'h30303531, 32'd20, 60, 2);
        expect_result();
        send_frame(SYM, 32'd20, 48, 2);
        expect_result();
        wait_quiet("nodec");

        axi_write(6'h20, 32'd0, 4'hF);
        old_thr = 32'd0;
        mask = 32'h0000FFFF;
        axi_write(6'h20, 32'h12345678, 4'b0011);
        axi_read(6'h20, rd);
        check_val("wstrb_rd", {32'd0, rd}, {32'd0, (old_thr & ~mask) | (32'h12345678 & mask)});
        axi_read(6'h3C, rd);
        check_val("rd_unmapped", {32'd0, rd}, 64'd0);
        axi_write(6'h24, 32'hDEADBEEF, 4'hF);
        axi_read(6'h24, rd);
        check_val("rd_0x24", {32'd0, rd}, 64'd0);

        for (int i = 0; i < 8; i++) axi_write(6'(i * 4), 32'd1, 4'hF);
        axi_write(6'h20, 32'd100, 4'hF);
        send_frame(SYM, 32'd20, 60, 2);
        send_frame(SYM, 32'd10, 60, 2);
        expect_result();
        expect_result();
        wait_quiet("b2b");

        axi_write(6'h00, 32'hFFFFFF38, 4'hF);
        axi_write(6'h20, 32'd0, 4'hF);
        send_frame(SYM, 32'd10, 60, 2);
        expect_result();
        wait_quiet("neg");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
